// File: rtl/key_press_conditioner.sv
// key_press_conditioner
// Turns one raw, active-low, bouncing pushbutton into a debounced level (held)
// and a single-cycle press pulse (pulse).
// Pipeline: two-flop synchronizer -> debounce counter -> press/release FSM -> registered one-shot.
// Optional build macro: KEY_PRESS_COUNT_EN adds an 8-bit saturating accepted-press counter (press_count).
//
// state    | meaning
// ---------+------------------------------------------------------
// RELEASED | debounced key is up; the next accepted press fires pulse
// PRESSED  | debounced key is down; waiting for an accepted release
module key_press_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    output logic       pulse,
    output logic       held
`ifdef KEY_PRESS_COUNT_EN
    ,
    output logic [7:0] press_count
`endif
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } state_t;

    // The synchronizer carries the pressed level (1 = pressed) and resets to released.
    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             held_q, held_d;
    state_t           state_q, state_d;
    logic             pulse_q, pulse_d;

    // Two-flop synchronizer for the asynchronous key input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= ~key_n;
            sync2_q <= sync1_q;
        end
    end

    // Debounce: accept a new level only after it differs for DEBOUNCE_CYCLES straight cycles.
    always_comb begin
        cnt_d  = cnt_q;
        held_d = held_q;
        if (sync2_q == held_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_TC) begin
            held_d = sync2_q;
            cnt_d  = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // FSM next state and one-shot: pulse on the accepted press edge only.
    always_comb begin
        state_d = state_q;
        pulse_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (held_d && !held_q) begin
                    state_d = PRESSED;
                    pulse_d = 1'b1;
                end
            end
            PRESSED: begin
                if (!held_d && held_q) begin
                    state_d = RELEASED;
                end
            end
            default: state_d = RELEASED;
        endcase
    end

    // Debounce, FSM and pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            held_q  <= 1'b0;
            state_q <= RELEASED;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            state_q <= state_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse = pulse_q;
    assign held  = held_q;

`ifdef KEY_PRESS_COUNT_EN
    logic [7:0] count_q, count_d;

    // Saturating count of accepted presses, cleared only by reset.
    always_comb begin
        count_d = count_q;
        if (pulse_d && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end
    end

    // Press counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign press_count = count_q;
`endif

endmodule

// File: tb/tb_key_press_conditioner.sv
// Testbench for key_press_conditioner (DEBOUNCE_CYCLES = 4).
// Segment table, hand-written latency/reset sequences and random stimulus, all
// compared against a window-based reference model of the debounce rule.
module tb_key_press_conditioner;

    localparam int D = 4;

    logic clk;
    logic reset;
    logic key_n;
    logic pulse;
    logic held;
`ifdef KEY_PRESS_COUNT_EN
    logic [7:0] press_count;
`endif

    int errors = 0;
    int checks = 0;

    key_press_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .reset       (reset),
        .key_n       (key_n),
        .pulse       (pulse),
        .held        (held)
`ifdef KEY_PRESS_COUNT_EN
        ,
        .press_count (press_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw samples delayed two edges; the accepted level flips
    // when the last D delayed samples all disagree with it.
    logic m_s1, m_s2;
    logic win[$];
    logic m_held, m_pulse;
    int   m_count;
    int   seg_pulses;

    function automatic void model_reset();
        m_s1 = 1'b0;
        m_s2 = 1'b0;
        win.delete();
        m_held  = 1'b0;
        m_pulse = 1'b0;
        m_count = 0;
    endfunction

    function automatic void model_edge(input logic k);
        logic all_diff;
        win.push_back(m_s2);
        if (win.size() > D) void'(win.pop_front());
        all_diff = (win.size() == D);
        foreach (win[j]) if (win[j] == m_held) all_diff = 1'b0;
        m_pulse = all_diff && !m_held;
        if (all_diff) m_held = ~m_held;
        if (m_pulse && m_count < 255) m_count++;
        m_s2 = m_s1;
        m_s1 = ~k;
    endfunction

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got=%b want=%b", name, $time, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d want=%0d", name, $time, got, want);
        end
    endtask

    // One clock: drive key, take the edge, compare against the model 1 ns later.
    task automatic tick(input logic k);
        key_n = k;
        @(posedge clk);
        model_edge(k);
        #1;
        check_bit("pulse", pulse, m_pulse);
        check_bit("held", held, m_held);
`ifdef KEY_PRESS_COUNT_EN
        check_int("press_count", int'(press_count), m_count);
`endif
        if (pulse === 1'b1) seg_pulses++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        model_reset();
        check_bit("rst_pulse", pulse, 1'b0);
        check_bit("rst_held", held, 1'b0);
        #2;
        reset = 1'b1;
    endtask

    typedef struct {
        logic  k;
        int    n;
        int    pulses;
        logic  held_end;
        string name;
    } seg_t;

    seg_t segs[$];
    int   first;

    initial begin
        reset = 1'b1;
        key_n = 1'b1;
        model_reset();
        #3;
        do_reset();

        // Segment table: {key level, cycles, pulses expected, held at end}.
        segs.push_back('{1'b1, 20, 0, 1'b0, "idle"});
        for (int i = 0; i < 6; i++)
            segs.push_back('{logic'(i % 2), 2, 0, 1'b0, "bounce"});
        segs.push_back('{1'b1, 10, 0, 1'b0, "post_bounce"});
        segs.push_back('{1'b0, 10, 1, 1'b1, "press1"});
        segs.push_back('{1'b1, 10, 0, 1'b0, "release1"});
        segs.push_back('{1'b0, 10, 1, 1'b1, "press2"});
        segs.push_back('{1'b0, 40, 0, 1'b1, "hold_long"});
        segs.push_back('{1'b1, 3,  0, 1'b1, "short_release"});
        segs.push_back('{1'b0, 10, 0, 1'b1, "back_to_hold"});
        segs.push_back('{1'b1, 10, 0, 1'b0, "release2"});

        foreach (segs[s]) begin
            seg_pulses = 0;
            for (int c = 0; c < segs[s].n; c++) tick(segs[s].k);
            check_int({segs[s].name, "_pulses"}, seg_pulses, segs[s].pulses);
            check_bit({segs[s].name, "_held"}, held, segs[s].held_end);
        end

        // Exact press latency: pulse and held appear after the 6th edge (k+1+D).
        seg_pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            tick(1'b0);
            check_bit("lat_held", held, logic'(i == 6));
            check_bit("lat_pulse", pulse, logic'(i == 6));
        end
        for (int i = 0; i < 50; i++) tick(1'b0);
        check_int("lat_total_pulses", seg_pulses, 1);
        check_bit("lat_held_end", held, 1'b1);

        // Release latency: held falls after the 6th edge, no pulse.
        seg_pulses = 0;
        for (int i = 1; i <= 6; i++) begin
            tick(1'b1);
            check_bit("rel_held", held, logic'(i < 6));
        end
        check_int("rel_pulses", seg_pulses, 0);
        for (int i = 0; i < 5; i++) tick(1'b1);

        // Reset during the pulse cycle with the key still held.
        first = 0;
        for (int i = 1; i <= 10 && first == 0; i++) begin
            tick(1'b0);
            if (pulse === 1'b1) first = i;
        end
        check_int("pre_reset_pulse_edge", first, 6);
        do_reset();
        first = 0;
        seg_pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0);
            if (pulse === 1'b1 && first == 0) first = i;
        end
        check_int("post_reset_pulse_edge", first, D + 2);
        check_int("post_reset_pulses", seg_pulses, 1);
        for (int i = 0; i < 8; i++) tick(1'b1);

        // Random runs of random length, checked cycle by cycle against the model.
        for (int r = 0; r < 120; r++) begin
            logic k;
            int   len;
            k   = logic'($urandom_range(0, 1));
            len = $urandom_range(1, 9);
            for (int c = 0; c < len; c++) tick(k);
        end
        for (int i = 0; i < 8; i++) tick(1'b1);

`ifdef KEY_PRESS_COUNT_EN
        do_reset();
        for (int p = 1; p <= 300; p++) begin
            for (int c = 0; c < 6; c++) tick(1'b0);
            check_int("count_seq", int'(press_count), (p > 255) ? 255 : p);
            for (int c = 0; c < 6; c++) tick(1'b1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
